ber_sweep_ctrl: RTL and testbench

- Sequences the BER checker through every receiver sampling phase and selects the phase with the fewest bit errors.
- Drives the checker's enable, phase select and bit-valid strobe.
- Waits for the checker's delay-adaptation lock at each phase, then counts error strobes over a fixed window.
- Finishes by parking the checker on the best phase. Sits between the top-level control (start button or VIO) and the checker/receiver pair.

---
 rtl/ber_pkg.sv | 19 +
 rtl/valid_strobe_gen.sv | 29 ++
 rtl/ber_sweep_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ber_sweep_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// ber_pkg: constants and FSM encoding for the BER phase sweep.
// Shared by the sweep controller and the strobe/PRBS blocks.
package ber_pkg;

  localparam int PRBS_LEN   = 1023;
  localparam int PHASE_BITS = 2;
  localparam int ERR_BITS   = 10;
  localparam int ERR_SAT    = (1 << ERR_BITS) - 1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ADAPT,
    MEASURE,
    EVAL,
    HOLD
  } state_t;

endpackage

// File: rtl/valid_strobe_gen.sv
// valid_strobe_gen: free-running divider, one-cycle strobe
// every VALID_DIV clocks on the last count.
module valid_strobe_gen #(
  parameter int VALID_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic valid
);

  localparam int CW = (VALID_DIV > 1) ? $clog2(VALID_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap  = cnt == CW'(VALID_DIV - 1);
  assign valid = wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ber_sweep_ctrl.sv
// ber_sweep_ctrl: sweeps receiver phases, scores each by BER,
// parks on the best. Lock-wait timeout: BER_SWEEP_TIMEOUT_EN.
module ber_sweep_ctrl
  import ber_pkg::*;
#(
  parameter int N_PHASES   = 4,
  parameter int PHASE_W    = PHASE_BITS,
  parameter int VALID_DIV  = 4,
  parameter int SETTLE_CYC = 16,
  parameter int WIN_BITS   = PRBS_LEN,
  parameter int ERR_W      = ERR_BITS
`ifdef BER_SWEEP_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1048576
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_locked,
  input  logic               i_err,
  output logic               o_enable,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [PHASE_W-1:0] o_best_phase,
  output logic [ERR_W-1:0]   o_best_err,
  output logic               o_led
`ifdef BER_SWEEP_TIMEOUT_EN
  ,
  output logic               o_timeout
`endif
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int BW = $clog2(WIN_BITS + 1);

  state_t state, nxt;

  logic               valid;
  logic [PHASE_W-1:0] idx;
  logic [SW-1:0]      set_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [ERR_W-1:0]   err_cnt;
  logic               last_ph;
  logic               settle_done;
  logic               win_done;
  logic               start_ok;
  logic               lock_to;

  valid_strobe_gen #(
    .VALID_DIV(VALID_DIV)
  ) u_strobe (
    .clk  (clk),
    .rst  (rst),
    .valid(valid)
  );

  assign o_valid     = valid;
  assign last_ph     = idx == PHASE_W'(N_PHASES - 1);
  assign settle_done = set_cnt == SW'(SETTLE_CYC - 1);
  assign win_done    = valid && (bit_cnt == BW'(WIN_BITS - 1));
  assign start_ok    = i_start && !i_abort &&
                       (state == IDLE || state == HOLD);

`ifdef BER_SWEEP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;

  assign lock_to = !i_locked &&
                   (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      to_cnt <= (state == ADAPT) ? to_cnt + 1'b1 : '0;
      if (start_ok) begin
        o_timeout <= 1'b0;
      end else if (state == ADAPT && lock_to && !i_abort) begin
        o_timeout <= 1'b1;
      end
    end
  end
`else
  assign lock_to = 1'b0;
`endif

  always_comb begin
    nxt      = state;
    o_enable = 1'b0;
    o_busy   = 1'b0;
    o_phase  = idx;
    o_led    = 1'b0;
    unique case (state)
      IDLE: begin
        o_phase = '0;
        if (i_start) nxt = SETTLE;
      end
      SETTLE: begin
        o_busy = 1'b1;
        if (settle_done) nxt = ADAPT;
      end
      ADAPT: begin
        o_busy   = 1'b1;
        o_enable = 1'b1;
        if (i_locked) nxt = MEASURE;
        else if (lock_to) nxt = EVAL;
      end
      MEASURE: begin
        o_busy   = 1'b1;
        o_enable = 1'b1;
        if (win_done) nxt = EVAL;
      end
      EVAL: begin
        o_busy   = 1'b1;
        o_enable = 1'b1;
        nxt      = last_ph ? HOLD : SETTLE;
      end
      HOLD: begin
        o_enable = 1'b1;
        o_phase  = o_best_phase;
        o_led    = o_best_err == '0;
        if (i_start) nxt = SETTLE;
      end
      default: nxt = IDLE;
    endcase
    if (i_abort) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      set_cnt      <= '0;
      bit_cnt      <= '0;
      err_cnt      <= '0;
      o_best_phase <= '0;
      o_best_err   <= '0;
      o_done       <= 1'b0;
    end else begin
      state   <= nxt;
      o_done  <= (state == EVAL) && (nxt == HOLD);
      set_cnt <= (state == SETTLE) ? set_cnt + 1'b1 : '0;
      if (start_ok) begin
        idx          <= '0;
        o_best_phase <= '0;
        o_best_err   <= '1;
      end
      // a timed-out lock wait scores the phase as worst case
      if (state == ADAPT) begin
        bit_cnt <= '0;
        err_cnt <= lock_to ? '1 : '0;
      end
      if (state == MEASURE && valid) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (i_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
      if (state == EVAL && nxt != IDLE) begin
        if (idx == '0 || err_cnt < o_best_err) begin
          o_best_phase <= idx;
          o_best_err   <= err_cnt;
        end
        if (!last_ph) idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// tb_ber_sweep_ctrl: directed sweeps with a done-event scoreboard.
// Define BER_SWEEP_TIMEOUT_EN to also cover the lock timeout.
module tb_ber_sweep_ctrl;

  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_locked = 1'b0;
  logic          i_err = 1'b0;
  logic          o_enable;
  logic [1:0]    o_phase;
  logic          o_valid;
  logic          o_busy;
  logic          o_done;
  logic [1:0]    o_best_phase;
  logic [EW-1:0] o_best_err;
  logic          o_led;
`ifdef BER_SWEEP_TIMEOUT_EN
  logic          o_timeout;
`endif

  ber_sweep_ctrl #(
    .ERR_W(EW)
`ifdef BER_SWEEP_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(100)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_locked    (i_locked),
    .i_err       (i_err),
    .o_enable    (o_enable),
    .o_phase     (o_phase),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_best_phase(o_best_phase),
    .o_best_err  (o_best_err),
    .o_led       (o_led)
`ifdef BER_SWEEP_TIMEOUT_EN
    ,
    .o_timeout   (o_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d", name, act);
  endtask

  typedef struct {
    int ph;
    int err;
    int led;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && o_done) begin
      if (sb.size() == 0) begin
        fail_now("done_unexpected", 1);
      end else begin
        e = sb.pop_front();
        check("done_best_phase", o_best_phase, e.ph);
        check("done_best_err", o_best_err, e.err);
        check("done_led", o_led, e.led);
        check("done_park_phase", o_phase, e.ph);
        check("done_enable", o_enable, 1);
      end
    end
  end

  function automatic int outs_vec();
    return int'({o_enable, o_busy, o_done, o_phase,
                 o_best_phase, o_best_err, o_led});
  endfunction

  task automatic push_exp(input int ph, input int err,
                          input int led);
    exp_t e;
    e.ph  = ph;
    e.err = err;
    e.led = led;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (sb.size() != 0) fail_now("done_missing", sb.size());
  endtask

  // ne < 0: i_err held high on every bit of that phase
  task automatic sweep(input int ne0, input int ne1,
                       input int ne2, input int ne3,
                       input int abort_ph, input int nolock_ph,
                       input int start_ph);
    int ne[4];
    int n;
    int cyc;
    bit all;
    ne = '{ne0, ne1, ne2, ne3};
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cyc = 0;
      while (!(o_enable && o_busy) && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 200) begin
        fail_now("adapt_timeout", p);
        return;
      end
      check("phase_seq", o_phase, p);
      if (p == nolock_ph) begin
        cyc = 0;
        while (o_enable && o_busy && cyc < 300) begin
          @(negedge clk);
          cyc++;
        end
        if (cyc >= 300) begin
          fail_now("lock_timeout_stuck", p);
          return;
        end
        continue;
      end
      repeat (50) @(negedge clk);
      i_locked = 1'b1;
      all = ne[p] < 0;
      n = 0;
      cyc = 0;
      while (cyc < 6000) begin
        @(negedge clk);
        cyc++;
        i_start = 1'b0;
        if (!o_busy || !o_enable) break;
        if (o_valid) begin
          n++;
          i_err = all || (n > 100 && n <= 100 + ne[p]);
        end else begin
          i_err = all;
        end
        if (p == start_ph && n == 20 && o_valid) i_start = 1'b1;
        if (p == abort_ph && n == 200 && o_valid) begin
          i_abort = 1'b1;
          @(negedge clk);
          i_abort  = 1'b0;
          i_locked = 1'b0;
          i_err    = 1'b0;
          check("abort_busy", o_busy, 0);
          check("abort_enable", o_enable, 0);
          check("abort_best_phase", o_best_phase, 0);
          check("abort_best_err", o_best_err, ne[0]);
          return;
        end
      end
      i_locked = 1'b0;
      i_err    = 1'b0;
      if (cyc >= 6000) begin
        fail_now("measure_timeout", p);
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs", outs_vec(), 0);
    check("rst_valid", o_valid, 0);
    rst = 1'b0;

    // cycle e+1 follows the e-th edge after the last reset edge
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      check("idle_valid", o_valid, ((e + 1) % 4 == 0) ? 1 : 0);
      check("idle_outs", outs_vec(), 0);
    end

    push_exp(2, 0, 1);
    sweep(9, 3, 0, 7, -1, -1, -1);
    wait_done();
    check("hold_phase", o_phase, 2);
    check("hold_enable", o_enable, 1);
    check("hold_led", o_led, 1);
    check("hold_busy", o_busy, 0);

    push_exp(0, 5, 0);
    sweep(5, 5, 8, 5, -1, -1, -1);
    wait_done();
    check("tie_led", o_led, 0);
    check("tie_phase", o_phase, 0);

    sweep(6, 10, 0, 0, 1, -1, -1);
    repeat (20) @(negedge clk);
    check("post_abort_busy", o_busy, 0);
    check("post_abort_phase", o_phase, 0);

    push_exp(3, 254, 0);
    sweep(300, -1, 256, 254, -1, -1, 1);
    wait_done();

`ifdef BER_SWEEP_TIMEOUT_EN
    push_exp(2, 2, 0);
    sweep(4, 99, 2, 6, -1, 1, -1);
    wait_done();
    check("timeout_sticky", o_timeout, 1);
`endif

    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
`ifdef BER_SWEEP_TIMEOUT_EN
    check("timeout_clear", o_timeout, 0);
`endif
    repeat (30) @(negedge clk);
    check("midrst_busy", o_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", outs_vec(), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_idle", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
